// File: rtl/ysyx_22041412_ifu_pkg.sv
// Shared constants and types for the ysyx_22041412 instruction fetch unit.
// Holds the default reset PC, the XLEN and instruction widths, the IFU state
// encodings and the packed layout of one instruction-buffer entry.
package ysyx_22041412_ifu_pkg;

  localparam int XLEN   = 64;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } ifu_state_e;

  // One buffered fetch: the PC travels with its instruction word.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } ifu_entry_t;

  localparam int ENTRY_W = $bits(ifu_entry_t);

  // Fetch addresses are always word aligned; the low two bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/ysyx_22041412_ifu_fifo.sv
// Small synchronous FIFO used as the IFU instruction buffer.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// flush empties the buffer and takes priority over push/pop in the same cycle.
module ysyx_22041412_ifu_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 96,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_en, pop_en;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push_en) - CW'(pop_en);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ysyx_22041412_ifu.sv
// Instruction fetch unit: sequential PC generation, single-outstanding
// instruction memory requests, a small instruction buffer and redirect flush.
// Optional performance counters are built when YSYX_22041412_IFU_PERF_EN is
// defined; otherwise the counter ports read as zero.
module ysyx_22041412_ifu
  import ysyx_22041412_ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [63:0] inst_pc,
  output logic        busy,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_stall_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;

  logic            accept;
  logic            fifo_push, fifo_pop, fifo_flush;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  ifu_entry_t      fifo_din, fifo_dout;

  // A request is only offered when the buffer can absorb its response, which
  // together with the single outstanding request keeps the FIFO from overflowing.
  assign imem_req_valid = (state_q == S_REQ) && !fifo_full;
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  // fetch_pc already advanced on accept, so the in-flight word belongs to pc-4.
  assign fifo_din.pc   = fetch_pc_q - 64'd4;
  assign fifo_din.inst = imem_resp_data;
  assign fifo_push     = (state_q == S_WAIT) && imem_resp_valid && !redirect_valid;
  assign fifo_pop      = inst_ready && !redirect_valid;
  assign fifo_flush    = redirect_valid;

  assign inst_valid = !fifo_empty;
  assign inst_data  = fifo_dout.inst;
  assign inst_pc    = fifo_dout.pc;
  assign busy       = (state_q != S_REQ) || (fifo_count != '0);

  ysyx_22041412_ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Fetch FSM next state; a redirect overrides normal sequencing.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
      case (state_q)
        S_REQ:          state_d = accept ? S_DROP : S_REQ;
        S_WAIT, S_DROP: state_d = imem_resp_valid ? S_REQ : S_DROP;
        default:        state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (accept) begin
            state_d    = S_WAIT;
            fetch_pc_d = fetch_pc_q + 64'd4;
          end
        end
        S_WAIT:  if (imem_resp_valid) state_d = S_REQ;
        S_DROP:  if (imem_resp_valid) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end
  end

  // FSM and fetch PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

`ifdef YSYX_22041412_IFU_PERF_EN
  logic [63:0] fetch_cnt_q, fetch_cnt_d;
  logic [63:0] stall_cnt_q, stall_cnt_d;

  // Saturating counters for delivered instructions and starved decode cycles.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (inst_valid && inst_ready && !redirect_valid && (fetch_cnt_q != '1)) begin
      fetch_cnt_d = fetch_cnt_q + 64'd1;
    end
    if (inst_ready && !inst_valid && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 64'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_22041412_ifu.sv
// Scoreboard testbench for ysyx_22041412_ifu.
// The driver plays instruction memory and decode; every accepted request
// pushes its expected {pc, word} onto a queue, a redirect wipes the queue, and
// an independent monitor pops and compares whenever decode takes an instruction.
module tb_ysyx_22041412_ifu;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;
  logic        busy;
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;

  ysyx_22041412_ifu dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .busy            (busy),
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_stall_cnt  (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  // Cycle number, stable between posedges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
    bit          responded;
    int          readyCyc;
  } exp_t;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } pend_t;

  exp_t        exp_q[$];
  pend_t       pend_q[$];
  logic [63:0] modelPc = RESET_PC;
  logic [63:0] mFetch = '0;
  logic [63:0] mStall = '0;
  bit          respDriven = 1'b0;
  bit          holdFlag = 1'b0;
  logic [63:0] holdAddr = '0;
  bit          expReqFlag = 1'b0;
  bit          lastAccept = 1'b0;
  int          acceptCnt = 0;
  int          errCount = 0;
  int          checkCount = 0;

  function automatic logic [31:0] memWord(input logic [63:0] a);
    return a[31:0] ^ {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
    checkCount++;
    if (act !== want) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst             = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    pend_q.delete();
    exp_q.delete();
    modelPc    = RESET_PC;
    mFetch     = '0;
    mStall     = '0;
    respDriven = 1'b0;
    holdFlag   = 1'b0;
    expReqFlag = 1'b0;
    #1;
    checkOutput("rst_inst_valid", inst_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_perf_fetch", perf_fetch_cnt, 0);
    checkOutput("rst_perf_stall", perf_stall_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One cycle of memory + decode behaviour; handshakes observed just before the edge.
  task automatic applyStimulus(input int readyPct, input int kMin, input int kMax,
                               input int irdyPct, input int redirPct,
                               input bit forceRedir, input logic [63:0] forcePc,
                               input bit stale);
    bit    accept;
    pend_t p;
    exp_t  e;
    @(negedge clk);
    imem_req_ready = (int'($urandom_range(99, 0)) < readyPct);
    respDriven     = 1'b0;
    if (stale) begin
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data  = $urandom;
    end else if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      p               = pend_q.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = memWord(p.addr);
      respDriven      = 1'b1;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (!exp_q[i].responded) begin
          e           = exp_q[i];
          e.responded = 1'b1;
          e.readyCyc  = cyc;
          exp_q[i]    = e;
          break;
        end
      end
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    inst_ready     = (int'($urandom_range(99, 0)) < irdyPct);
    redirect_valid = forceRedir || (int'($urandom_range(99, 0)) < redirPct);
    redirect_pc    = forceRedir ? forcePc : 64'h8000_0000 + 64'($urandom_range(16'hFFFF, 0));
    #3;
    if (holdFlag) begin
      checkOutput("req_hold_valid", imem_req_valid, 1);
      checkOutput("req_hold_addr", imem_req_addr, holdAddr);
    end
    if (expReqFlag) begin
      checkOutput("redir_req_valid", imem_req_valid, 1);
      checkOutput("redir_req_addr", imem_req_addr, modelPc);
    end
    accept = imem_req_valid && imem_req_ready;
    if (accept) begin
      checkOutput("req_addr", imem_req_addr, modelPc);
      exp_q.push_back('{modelPc, memWord(modelPc), 1'b0, 0});
      pend_q.push_back('{imem_req_addr, cyc + int'($urandom_range(kMax, kMin))});
      modelPc = modelPc + 64'd4;
      acceptCnt++;
    end
    if (redirect_valid) begin
      exp_q.delete();
      modelPc = redirect_pc & ~64'h3;
    end
    holdFlag   = imem_req_valid && !imem_req_ready && !redirect_valid;
    holdAddr   = imem_req_addr;
    expReqFlag = redirect_valid && (pend_q.size() == 0);
    lastAccept = accept;
  endtask

  // Monitor: checks valid/busy/counters every cycle and pops on each delivery.
  initial begin : monitor
    bit   expValid;
    bit   expBusy;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        expValid = exp_q.size() > 0 && exp_q[0].responded && exp_q[0].readyCyc < cyc;
        checkOutput("inst_valid", inst_valid, expValid);
        expBusy = (pend_q.size() > 0) || respDriven || expValid;
        checkOutput("busy", busy, expBusy);
        checkOutput("perf_fetch", perf_fetch_cnt, mFetch);
        checkOutput("perf_stall", perf_stall_cnt, mStall);
        if (expValid && inst_valid && inst_ready && !redirect_valid) begin
          e = exp_q.pop_front();
          checkOutput("inst_pc", inst_pc, e.pc);
          checkOutput("inst_data", inst_data, e.data);
        end
`ifdef YSYX_22041412_IFU_PERF_EN
        if (expValid && inst_ready && !redirect_valid && mFetch != '1) mFetch = mFetch + 1;
        if (!expValid && inst_ready && mStall != '1) mStall = mStall + 1;
`endif
      end
    end
  end

  initial begin : driver
    bit seen;
    doReset();

    // Streaming fetch: one accept every two cycles with a 1-cycle memory.
    acceptCnt = 0;
    repeat (20) applyStimulus(100, 1, 1, 100, 0, 1'b0, '0, 1'b0);
    checkOutput("t1_throughput", 64'(acceptCnt), 10);

    // Decode stalled: buffer fills to two words and requests stop.
    doReset();
    repeat (10) applyStimulus(100, 1, 1, 0, 0, 1'b0, '0, 1'b0);
    checkOutput("t2_req_valid", imem_req_valid, 0);
    checkOutput("t2_busy", busy, 1);
    checkOutput("t2_head_pc", inst_pc, RESET_PC);
    repeat (20) applyStimulus(100, 1, 1, 100, 0, 1'b0, '0, 1'b0);

    // Redirect while a request is in flight.
    doReset();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      applyStimulus(100, 4, 4, 100, 0, 1'b0, '0, 1'b0);
      seen = lastAccept;
    end
    if (!seen) checkOutput("t3_accept_timeout", 0, 1);
    applyStimulus(100, 4, 4, 100, 0, 1'b1, 64'h0000_0000_8000_1002, 1'b0);
    checkOutput("t3_in_wait", imem_req_valid, 0);
    repeat (30) applyStimulus(100, 1, 1, 100, 0, 1'b0, '0, 1'b0);

    // Redirect coinciding with a response and a pop.
    doReset();
    repeat (5) applyStimulus(100, 2, 2, 0, 0, 1'b0, '0, 1'b0);
    applyStimulus(100, 2, 2, 100, 0, 1'b1, 64'h0000_0000_8000_2000, 1'b0);
    repeat (20) applyStimulus(100, 1, 2, 100, 0, 1'b0, '0, 1'b0);

    // Reset in the middle of a fetch, followed by a stale response.
    doReset();
    repeat (6) applyStimulus(100, 3, 3, 0, 0, 1'b0, '0, 1'b0);
    doReset();
    applyStimulus(100, 1, 1, 100, 0, 1'b0, '0, 1'b1);
    repeat (30) applyStimulus(100, 1, 1, 100, 0, 1'b0, '0, 1'b0);

    // Randomised traffic.
    for (int r = 0; r < 3; r++) begin
      doReset();
      repeat (250) applyStimulus(70, 1, 4, 60, 3, 1'b0, '0, 1'b0);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
